// File: rtl/eval_sequencer.sv
// Multi-cycle evaluator: out1 = a + b*c - p**k - (sel ? 10 : 0), modulo 2**WIDTH, on one shared multiplier.
// Define EVAL_SEQUENCER_POW_EN to enable the POW state; otherwise the power term is in_p and in_k is ignored.
module eval_sequencer #(
    parameter int WIDTH = 2**2 * 2**3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic [WIDTH-1:0]     in_p,
    input  logic [3:0]           in_k,
    input  logic                 in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out1,
    output logic [2*WIDTH-1:0]   out2,
    output logic [15:0]          op_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
`ifdef EVAL_SEQUENCER_POW_EN
        POW  = 3'd2,
`endif
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, c_r, p_r;
    logic             sel_r;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] mul_x, mul_y, mul_lo;
    logic [WIDTH-1:0] pow_term;
    logic [WIDTH-1:0] sum;

`ifdef EVAL_SEQUENCER_POW_EN
    logic [3:0]       k_r;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] acc;
`else
    logic             k_unused;
    assign k_unused = ^in_k;
`endif

    // Final combination with the optional -10 constant, all modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] final_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] prod,
        input logic [WIDTH-1:0] pw,
        input logic             sel
    );
        logic [WIDTH-1:0] base;
        base = a + prod - pw;
        return sel ? base - WIDTH'(10) : base;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // The single multiplier serves b*c in MUL and acc*p in POW.
    always_comb begin
        mul_x = b_r;
        mul_y = c_r;
`ifdef EVAL_SEQUENCER_POW_EN
        if (state == POW) begin
            mul_x = acc;
            mul_y = p_r;
        end
`endif
    end

    assign mul_lo = mul_x * mul_y;

`ifdef EVAL_SEQUENCER_POW_EN
    assign pow_term = acc;
`else
    assign pow_term = p_r;
`endif

    assign sum = final_sum(a_r, product, pow_term, sel_r);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            out1     <= '0;
            out2     <= '0;
            op_count <= '0;
            product  <= '0;
`ifdef EVAL_SEQUENCER_POW_EN
            acc      <= '0;
            cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        c_r   <= in_c;
                        p_r   <= in_p;
                        sel_r <= in_sel;
`ifdef EVAL_SEQUENCER_POW_EN
                        k_r   <= in_k;
`endif
                        state <= MUL;
                    end
                end
                MUL: begin
                    product <= mul_lo;
`ifdef EVAL_SEQUENCER_POW_EN
                    acc   <= WIDTH'(1);
                    cnt   <= k_r;
                    state <= (k_r != 4'd0) ? POW : ADD;
`else
                    state <= ADD;
`endif
                end
`ifdef EVAL_SEQUENCER_POW_EN
                POW: begin
                    acc <= mul_lo;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ADD;
                end
`endif
                ADD: begin
                    out1 <= sum;
                    // out2 only follows out1 when the new result has bit 1 set.
                    if (sum[1]) out2 <= {{WIDTH{1'b0}}, sum};
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eval_sequencer.sv
// Bench for eval_sequencer: directed and random operand sets against an arithmetic reference model.
module tb_eval_sequencer;

    localparam int WIDTH = 32;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0, in_b = '0, in_c = '0, in_p = '0;
    logic [3:0]         in_k = '0;
    logic               in_sel = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out1;
    logic [2*WIDTH-1:0] out2;
    logic [15:0]        op_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_out2 = '0;
    logic [15:0] exp_op_count = '0;

    eval_sequencer #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_p(in_p),
        .in_k(in_k), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out1(out1), .out2(out2), .op_count(op_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model_out1(input logic [31:0] a, b, c, p,
                                               input logic [3:0] k, input logic sel);
        logic [31:0] pw;
`ifdef EVAL_SEQUENCER_POW_EN
        pw = 32'd1;
        for (int i = 0; i < int'(k); i++) pw = pw * p;
`else
        pw = p;
`endif
        return a + b * c - pw - (sel ? 32'd10 : 32'd0);
    endfunction

    function automatic int model_latency(input logic [3:0] k);
`ifdef EVAL_SEQUENCER_POW_EN
        return int'(k) + 2;
`else
        return 2;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, b, c, p, input logic [3:0] k,
                          input logic sel, input int stall);
        logic [31:0] e1;
        logic [31:0] held;
        int          n;
        e1 = model_out1(a, b, c, p, k, sel);
        in_a = a; in_b = b; in_c = c; in_p = p; in_k = k; in_sel = sel;
        in_valid = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_c = $urandom; in_p = $urandom;
        in_k = 4'($urandom); in_sel = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = 1'($urandom);
            @(posedge clock); #1;
            n++;
        end
        check("latency", 64'(n), 64'(model_latency(k)));
        if (e1[1]) exp_out2 = {32'd0, e1};
        check("out1", 64'(out1), 64'(e1));
        check("out2", out2, exp_out2);
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        held = out1;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            @(posedge clock); #1;
        end
        if (stall > 0) begin
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out1", 64'(out1), 64'(held));
            check("stall_out2", out2, exp_out2);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_op_count", 64'(op_count), 64'(exp_op_count));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        exp_op_count = exp_op_count + 16'd1;
        check("op_count", 64'(op_count), 64'(exp_op_count));
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Power-on reset
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out1", 64'(out1), 64'd0);
        check("rst_out2", out2, 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;

        // Directed sets: sel off/on, k=0, long stall
        run_op(32'd1, 32'd2, 32'd12, 32'd3, 4'd5, 1'b0, 0);
        run_op(32'd1, 32'd2, 32'd12, 32'd3, 4'd5, 1'b1, 1);
        run_op(32'd5, 32'd0, 32'd0, 32'd7, 4'd0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 1'b1, 10);
        run_op(32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 2);

        // Reset in the middle of an operation with k=9
        in_a = 32'd9; in_b = 32'd3; in_c = 32'd4; in_p = 32'd2; in_k = 4'd9; in_sel = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out1", 64'(out1), 64'd0);
        check("midrst_out2", out2, 64'd0);
        check("midrst_op_count", 64'(op_count), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_out2 = '0;
        exp_op_count = '0;
        @(posedge clock); #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        check("postrst_out_valid", 64'(out_valid), 64'd0);
        run_op(32'd1, 32'd2, 32'd12, 32'd3, 4'd5, 1'b0, 0);

        // Random operand sets
        for (int r = 0; r < 25; r++) begin
            run_op($urandom, $urandom, $urandom, 32'($urandom_range(0, 9)),
                   4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eval_sequencer.md
EVAL_SEQUENCER -- requirements
Module: eval_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 2**2 * 2**3 (32), datapath width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept an operand set.
REQ-006 SHALL have ports in_a, in_b, in_c, in_p  input  WIDTH each  operands.
REQ-007 SHALL have port in_k  input  4  exponent for the power term.
REQ-008 SHALL have port in_sel  input  1  constant-term select.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out1  output reg  WIDTH  result.
REQ-012 SHALL have port out2  output reg  2*WIDTH  zero-extended out1, conditionally updated.
REQ-013 SHALL have port op_count  output reg  16  completed output handshakes.

Function
REQ-014 SHALL compute out1 = in_a + in_b*in_c - in_p**in_k + (in_sel ? -10 : 0), all terms truncated modulo 2**WIDTH, unsigned wrap.
REQ-015 SHALL use one shared WIDTH x WIDTH multiplier (low WIDTH bits kept) for both b*c and the power iterations.
REQ-016 SHALL implement states IDLE, MUL, POW, ADD, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready register all operands, go to MUL.
REQ-018 MUL: product <= b*c; acc <= 1; cnt <= k; go to POW if k!=0, else ADD.
REQ-019 POW: acc <= acc*p; cnt <= cnt-1; go to ADD when cnt==1; p**0 SHALL equal 1.
REQ-020 ADD: out1 <= final sum; if the new out1 bit 1 is 1, out2 <= {WIDTH zeros, new out1}, else out2 holds; go to DONE.
REQ-021 DONE: out_valid=1, out1/out2 stable until out_valid&out_ready; then op_count increments (wraps 0xFFFF->0) and state goes to IDLE.
REQ-022 in_ready SHALL be 1 only in IDLE; no acceptance in the same cycle as an output handshake.
REQ-023 out_valid SHALL rise exactly k+2 rising edges after the accepting edge.
REQ-024 in_valid while busy SHALL be ignored; operand changes after acceptance SHALL not affect the result.
REQ-025 out_ready low in DONE SHALL stall indefinitely without loss or change of outputs.

Reset
REQ-026 reset_n low at a rising edge SHALL force IDLE, out_valid=0, out1=0, out2=0, op_count=0, acc/cnt/product=0.
REQ-027 Reset mid-operation (any state) SHALL discard the in-flight operand set with no output handshake; in_ready=1 on the first edge after reset_n returns high.

Configuration
REQ-028 Macro EVAL_SEQUENCER_POW_EN defined: POW state and in_k behaviour per REQ-018..REQ-019, latency k+2.
REQ-029 Macro EVAL_SEQUENCER_POW_EN undefined: POW state absent, in_k ignored, power term equals in_p, MUL goes directly to ADD, latency fixed at 2 edges.

Verification (WIDTH=32, macro defined unless stated)
REQ-030 a=1,b=2,c=12,p=3,k=5,sel=0 -> out1=0xFFFFFF26, out2=0x00000000_FFFFFF26, out_valid after 7 edges.
REQ-031 Then a=1,b=2,c=12,p=3,k=5,sel=1 -> out1=0xFFFFFF1C, out2 unchanged at 0x00000000_FFFFFF26.
REQ-032 a=5,b=0,c=0,p=7,k=0,sel=0 -> out1=0x00000004, out_valid after 2 edges, out2 unchanged.
REQ-033 out_ready held low 10 cycles in DONE, in_valid toggled -> outputs stable, in_ready=0, op_count increments by exactly 1 on release.
REQ-034 reset_n pulsed low during POW with k=9 -> out_valid never asserts, all outputs 0, next operand set accepted and correct.
REQ-035 Macro undefined: a=1,b=2,c=12,p=3,k=5,sel=0 -> out1=0x00000016 (22), out2=0x00000000_00000016, out_valid after 2 edges.
